// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: two-digit BCD up/down counter with load/stop/start control, prescaler and target detect.
// Define BCD_COUNT_CTRL_AUTORELOAD_EN to reload from the preset on a target hit instead of stopping.
module bcd_count_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       up_down,
    input  logic [7:0] target,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       done,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] reload_q, reload_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    logic       carry_q, carry_d, done_q, done_d, busy_q, busy_d, pend_q, pend_d;
    logic [3:0] ld_ones, ld_tens, up_ones, up_tens, dn_ones, dn_tens, st_ones, st_tens;
    logic       up_wrap, dn_wrap, step, hit;

    // Out-of-range preset digits saturate at 9 so the count is always valid BCD
    assign ld_ones = load_val[3:0] > 4'd9 ? 4'd9 : load_val[3:0];
    assign ld_tens = load_val[7:4] > 4'd9 ? 4'd9 : load_val[7:4];

    assign up_ones = ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1;
    assign up_tens = ones_q != 4'd9 ? tens_q : (tens_q == 4'd9 ? 4'd0 : tens_q + 4'd1);
    assign up_wrap = ones_q == 4'd9 && tens_q == 4'd9;
    assign dn_ones = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
    assign dn_tens = ones_q != 4'd0 ? tens_q : (tens_q == 4'd0 ? 4'd9 : tens_q - 4'd1);
    assign dn_wrap = ones_q == 4'd0 && tens_q == 4'd0;
    assign st_ones = up_down ? up_ones : dn_ones;
    assign st_tens = up_down ? up_tens : dn_tens;

    assign step = state_q == RUN && pre_q == PRE_LAST;
    // A pending reload step shows the preset, so it never counts as a hit
    assign hit  = step && !pend_q && {st_tens, st_ones} == target;

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        reload_d = reload_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        carry_d  = 1'b0;
        done_d   = state_q == DONE;
        pend_d   = pend_q;
        if (load) begin
            ones_d   = ld_ones;
            tens_d   = ld_tens;
            reload_d = {ld_tens, ld_ones};
            state_d  = IDLE;
            pre_d    = 8'd0;
            done_d   = 1'b0;
            pend_d   = 1'b0;
        end else if (stop) begin
            if (state_q == RUN)
                state_d = PAUSE;
        end else if (start && state_q != RUN) begin
            state_d = RUN;
            done_d  = 1'b0;
            if (state_q != PAUSE)
                pre_d = 8'd0;
        end else if (state_q == RUN) begin
            pre_d = step ? 8'd0 : pre_q + 8'd1;
            if (step && pend_q) begin
                ones_d = reload_q[3:0];
                tens_d = reload_q[7:4];
                pend_d = 1'b0;
            end else if (step) begin
                ones_d  = st_ones;
                tens_d  = st_tens;
                carry_d = up_down ? up_wrap : dn_wrap;
                if (hit) begin
                    done_d = 1'b1;
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
                    pend_d = 1'b1;
`else
                    state_d = DONE;
`endif
                end
            end
        end
        busy_d = state_d == RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pre_q    <= 8'd0;
            reload_q <= 8'h00;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            reload_q <= reload_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
        end
    end

    assign ones  = ones_q;
    assign tens  = tens_q;
    assign carry = carry_q;
    assign done  = done_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: drives a PRESCALE=1 and a PRESCALE=3 counter with shared stimulus
// and checks both against an integer-valued reference model every cycle.
module tb_bcd_count_ctrl;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0, reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, load = 1'b0, up_down = 1'b1;
    logic [7:0] load_val = 8'h00, target = 8'h00;
    logic [3:0] d_ones [2];
    logic [3:0] d_tens [2];
    logic       d_carry [2];
    logic       d_done [2];
    logic       d_busy [2];

    int n_cmp = 0, n_bad = 0;
    int m_val [2], m_rel [2], m_mode [2], m_pre [2];
    bit m_carry [2], m_done [2], m_busy [2], m_pend [2];

    bcd_count_ctrl #(.PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .up_down(up_down), .target(target),
        .ones(d_ones[0]), .tens(d_tens[0]), .carry(d_carry[0]), .done(d_done[0]), .busy(d_busy[0])
    );

    bcd_count_ctrl #(.PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .up_down(up_down), .target(target),
        .ones(d_ones[1]), .tens(d_tens[1]), .carry(d_carry[1]), .done(d_done[1]), .busy(d_busy[1])
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp9(input int d);
        return d > 9 ? 9 : d;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [7:0] dut_val(input int i);
        return {d_tens[i], d_ones[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_rel[i] = 0; m_mode[i] = M_IDLE; m_pre[i] = 0;
            m_carry[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int ps, nxt;
        bit wrap, tgt_ok;
        ps = i == 0 ? 1 : 3;
        tgt_ok = target[7:4] <= 9 && target[3:0] <= 9;
        m_carry[i] = 0;
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
        m_done[i] = 0;
`endif
        if (load) begin
            m_val[i] = 10 * clamp9(int'(load_val[7:4])) + clamp9(int'(load_val[3:0]));
            m_rel[i] = m_val[i];
            m_mode[i] = M_IDLE; m_pre[i] = 0; m_done[i] = 0; m_pend[i] = 0;
        end else if (stop) begin
            if (m_mode[i] == M_RUN) m_mode[i] = M_PAUSE;
        end else if (start && m_mode[i] != M_RUN) begin
            if (m_mode[i] != M_PAUSE) m_pre[i] = 0;
            m_mode[i] = M_RUN;
            m_done[i] = 0;
        end else if (m_mode[i] == M_RUN) begin
            m_pre[i]++;
            if (m_pre[i] == ps) begin
                m_pre[i] = 0;
                if (m_pend[i]) begin
                    m_val[i] = m_rel[i];
                    m_pend[i] = 0;
                end else begin
                    wrap = up_down ? m_val[i] == 99 : m_val[i] == 0;
                    nxt = up_down ? (m_val[i] + 1) % 100 : (m_val[i] + 99) % 100;
                    m_val[i] = nxt;
                    m_carry[i] = wrap;
                    if (tgt_ok && nxt == 10 * int'(target[7:4]) + int'(target[3:0])) begin
                        m_done[i] = 1;
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
                        m_pend[i] = 1;
`else
                        m_mode[i] = M_DONE;
`endif
                    end
                end
            end
        end
        m_busy[i] = m_mode[i] == M_RUN;
    endtask

    task automatic compare_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("p%0d_count", i), dut_val(i), to_bcd(m_val[i]));
            check($sformatf("p%0d_carry", i), d_carry[i], m_carry[i]);
            check($sformatf("p%0d_done", i), d_done[i], m_done[i]);
            check($sformatf("p%0d_busy", i), d_busy[i], m_busy[i]);
        end
    endtask

    task automatic cyc();
        for (int i = 0; i < 2; i++) model_edge(i);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_cmd(input bit l, input bit sp, input bit st);
        load = l; stop = sp; start = st;
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_rst_count%0d", tag, i), dut_val(i), 8'h00);
            check($sformatf("%s_rst_flags%0d", tag, i), {d_carry[i], d_done[i], d_busy[i]}, 3'b000);
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] seq36 [5];
        seq36 = '{8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
        model_reset();
        #1;
        check("por_count", dut_val(0), 8'h00);
        check("por_flags", {d_carry[0], d_done[0], d_busy[0]}, 3'b000);
        @(posedge clk);
        #1 reset = 1'b0;
        compare_model();

        // Count up from 07 to target 12, then hold in DONE
        load_val = 8'h07; up_down = 1'b1; target = 8'h12;
        set_cmd(1, 0, 1); cyc();
        check("t36_load", dut_val(0), 8'h07);
        check("t36_idle", d_busy[0], 1'b0);
        set_cmd(0, 0, 1); cyc();
        check("t36_busy", d_busy[0], 1'b1);
        set_cmd(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check($sformatf("t36_seq%0d", k), dut_val(0), seq36[k]);
        end
        check("t36_done", {d_done[0], d_busy[0]}, 2'b10);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("t36_hold", {dut_val(0), d_done[0], d_busy[0]}, {8'h12, 2'b10});
        end

        // Up through the 99 -> 00 wrap onto target 01
        load_val = 8'h98; target = 8'h01;
        set_cmd(1, 0, 0); cyc();
        set_cmd(0, 0, 1); cyc();
        set_cmd(0, 0, 0);
        cyc(); check("t37_99", {dut_val(0), d_carry[0]}, {8'h99, 1'b0});
        cyc(); check("t37_00", {dut_val(0), d_carry[0]}, {8'h00, 1'b1});
        cyc(); check("t37_01", {dut_val(0), d_carry[0], d_done[0]}, {8'h01, 1'b0, 1'b1});

        // Down through 00 -> 99, pause, resume
        load_val = 8'h01; up_down = 1'b0; target = 8'h50;
        set_cmd(1, 0, 0); cyc();
        set_cmd(0, 0, 1); cyc();
        set_cmd(0, 0, 0);
        cyc(); check("t38_00", {dut_val(0), d_carry[0]}, {8'h00, 1'b0});
        cyc(); check("t38_99", {dut_val(0), d_carry[0]}, {8'h99, 1'b1});
        set_cmd(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t38_pause", {dut_val(0), d_carry[0], d_busy[0]}, {8'h99, 2'b00});
        end
        set_cmd(0, 0, 1); cyc();
        set_cmd(0, 0, 0); cyc();
        check("t38_resume", dut_val(0), 8'h98);

        // PRESCALE=3 step spacing, then asynchronous reset between steps
        load_val = 8'h00; up_down = 1'b1; target = 8'h50;
        set_cmd(1, 0, 0); cyc();
        set_cmd(0, 0, 1); cyc();
        set_cmd(0, 0, 0);
        cyc(); cyc(); check("t39_n2", dut_val(1), 8'h00);
        cyc(); check("t39_n3", dut_val(1), 8'h01);
        cyc(); cyc(); check("t39_n5", dut_val(1), 8'h01);
        cyc(); check("t39_n6", dut_val(1), 8'h02);
        cyc();
        async_reset("t39");
        cyc(); check("t39_idle", {dut_val(1), d_busy[1]}, {8'h00, 1'b0});

        // Clamp on load, and load beating stop/start
        load_val = 8'hFA;
        set_cmd(1, 0, 0); cyc();
        check("t40_clamp", dut_val(0), 8'h99);
        load_val = 8'h42;
        set_cmd(1, 1, 1); cyc();
        check("t40_prio", {dut_val(0), d_busy[0]}, {8'h42, 1'b0});
        set_cmd(0, 0, 0); cyc();
        check("t40_idle", d_busy[0], 1'b0);

        // Target hit at 07 from preset 05
        load_val = 8'h05; target = 8'h07; up_down = 1'b1;
        set_cmd(1, 0, 0); cyc();
        set_cmd(0, 0, 1); cyc();
        set_cmd(0, 0, 0);
        cyc(); check("t41_06", dut_val(0), 8'h06);
        cyc(); check("t41_07", {dut_val(0), d_done[0]}, {8'h07, 1'b1});
`ifdef BCD_COUNT_CTRL_AUTORELOAD_EN
        check("t41_busy", d_busy[0], 1'b1);
        cyc(); check("t41_05", {dut_val(0), d_done[0], d_busy[0]}, {8'h05, 2'b01});
        cyc(); check("t41_06b", {dut_val(0), d_done[0], d_busy[0]}, {8'h06, 2'b01});
        cyc(); check("t41_07b", {dut_val(0), d_done[0], d_busy[0]}, {8'h07, 2'b11});
`else
        check("t41_busy", d_busy[0], 1'b0);
        cyc(); check("t41_hold", {dut_val(0), d_done[0]}, {8'h07, 1'b1});
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            load = $urandom_range(99) < 4;
            stop = $urandom_range(99) < 8;
            start = $urandom_range(99) < 30;
            if ($urandom_range(9) == 0) up_down = 1'($urandom);
            if ($urandom_range(99) < 5)
                load_val = $urandom_range(9) == 0 ? 8'($urandom) : to_bcd($urandom_range(99));
            if ($urandom_range(99) < 3)
                target = $urandom_range(9) == 0 ? 8'($urandom) : to_bcd($urandom_range(99));
            cyc();
            if ($urandom_range(299) == 0) async_reset("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bcd_count_ctrl.md
BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 Parameter: PRESCALE, default 1, number of RUN cycles per count step (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level-sampled command: begin or resume counting.
REQ-005 stop  input  1  level-sampled command: pause counting.
REQ-006 load  input  1  level-sampled command: load load_val and return to IDLE.
REQ-007 load_val  input  8  BCD preset {tens[7:4], ones[3:0]}.
REQ-008 up_down  input  1  count direction; 1 = up, 0 = down.
REQ-009 target  input  8  BCD terminal value {tens, ones}.
REQ-010 ones  output  4  BCD ones digit, registered.
REQ-011 tens  output  4  BCD tens digit, registered.
REQ-012 carry  output  1  one-cycle wrap pulse, registered.
REQ-013 done  output  1  terminal-count indication, registered.
REQ-014 busy  output  1  high while in RUN, registered.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-016 Command priority each cycle SHALL be load > stop > start.
REQ-017 load in any state: {tens, ones} <= load_val at the next edge, reload register <= load_val, state -> IDLE, prescaler cleared.
REQ-018 Any load_val digit above 9 SHALL be clamped to 9 (e.g. 8'hA3 loads 93).
REQ-019 start in IDLE, PAUSE or DONE -> RUN; busy goes high at the same edge.
REQ-020 stop in RUN -> PAUSE; count and prescaler are held.
REQ-021 Entry to RUN from IDLE or DONE clears the prescaler; entry from PAUSE resumes it.
REQ-022 In RUN, a count step SHALL occur every PRESCALE cycles.
REQ-023 The first step after start sampled at edge N SHALL occur at edge N+PRESCALE.
REQ-024 up_down SHALL be sampled on each step cycle, not latched at start.
REQ-025 Up step: ones 9 -> 0 with tens incremented; 99 -> 00 asserts carry for one cycle.
REQ-026 Down step: ones 0 -> 9 with tens decremented; 00 -> 99 asserts carry for one cycle.
REQ-027 Target compare SHALL use the post-step value and only on step cycles; a count already equal to target at start does not hit.
REQ-028 On a hit (feature off): state -> DONE at the same edge, done high and busy low until the next start or load.
REQ-029 carry and a hit on the same step SHALL both be reported.
REQ-030 Outputs SHALL never hold a non-BCD digit value.

Reset
REQ-031 reset SHALL force: state IDLE, ones=0, tens=0, carry=0, done=0, busy=0, prescaler=0, reload register=00.
REQ-032 reset asserted mid-RUN SHALL take effect immediately, asynchronously; after release the block waits in IDLE for start.

Configuration
REQ-033 Macro BCD_COUNT_CTRL_AUTORELOAD_EN SHALL select auto-reload behaviour.
REQ-034 With the macro defined, a hit SHALL reload the count from the reload register, stay in RUN, and pulse done for one cycle; DONE is unreachable.
REQ-035 Without the macro, hit behaviour SHALL follow REQ-028.

Verification (PRESCALE=1 unless stated)
REQ-036 Reset, then load 8'h07 with start=1 and up=1, target=8'h12: count reads 08, 09, 10, 11, 12; done rises with 12; busy falls; hold 2 cycles with no change.
REQ-037 Load 8'h98 with up=1, target=8'h01: steps 99 -> 00 with carry high for exactly that cycle, then 01 with done high.
REQ-038 Load 8'h01 with up=0 and start: steps 00 -> 99 with one carry pulse; stop for 3 cycles holds 99; start resumes with 98.
REQ-039 PRESCALE=3: start at edge N gives steps at N+3 and N+6; reset pulsed between steps -> all outputs 0 immediately, state IDLE.
REQ-040 Load 8'hFA: reads 99. Then load, stop and start asserted together: load wins and the state is IDLE.
REQ-041 With BCD_COUNT_CTRL_AUTORELOAD_EN defined, load 8'h05, target=8'h07, up=1: sequence 06, 07 (done pulse), 05, 06, 07 (done pulse); busy stays high throughout.
